// File: rtl/flex_adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle serial adder.
package flex_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of slices needed to cover the full operand width.
  function automatic int calc_num_slices(input int num_bits, input int slice_bits);
    return num_bits / slice_bits;
  endfunction

  // Slice index width; a single-slice build still needs a one-bit counter.
  function automatic int calc_idx_width(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

endpackage

// File: rtl/adder_nbit.sv
// Combinational N-bit ripple adder with carry-in; overflow is the carry out of the MSB.
module adder_nbit #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] sum,
  output logic         overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {{N{1'b0}}, carry_in};

endmodule

// File: rtl/flex_serial_adder.sv
// Multi-cycle adder: adds SLICE_BITS per clock from the LSB slice upward,
// carrying between slices through a register, with a start/busy/done handshake.
module flex_serial_adder
  import flex_adder_pkg::*;
#(
  parameter int NUM_BITS   = 16,
  parameter int SLICE_BITS = 4
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  input  logic                carry_in,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] sum,
  output logic                overflow
);

  localparam int NUM_SLICES = calc_num_slices(NUM_BITS, SLICE_BITS);
  localparam int IDX_W      = calc_idx_width(NUM_SLICES);

  localparam logic [IDX_W-1:0]    LAST_IDX   = IDX_W'(NUM_SLICES - 1);
  localparam logic [NUM_BITS-1:0] SLICE_MASK = NUM_BITS'({SLICE_BITS{1'b1}});

  state_t              state_q, state_d;
  logic [NUM_BITS-1:0] a_q, a_d;
  logic [NUM_BITS-1:0] b_q, b_d;
  logic                carry_q, carry_d;
  logic [NUM_BITS-1:0] work_q, work_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [NUM_BITS-1:0] sum_q, sum_d;
  logic                overflow_q, overflow_d;

  int                    slice_lsb;
  logic [NUM_BITS-1:0]   a_shift;
  logic [NUM_BITS-1:0]   b_shift;
  logic [SLICE_BITS-1:0] slice_a;
  logic [SLICE_BITS-1:0] slice_b;
  logic [SLICE_BITS-1:0] slice_sum;
  logic                  slice_carry;
  logic [NUM_BITS-1:0]   work_merged;

  // Select the operand slice addressed by the slice index and prepare the merged working sum.
  always_comb begin
    slice_lsb   = int'(idx_q) * SLICE_BITS;
    a_shift     = a_q >> slice_lsb;
    b_shift     = b_q >> slice_lsb;
    slice_a     = a_shift[SLICE_BITS-1:0];
    slice_b     = b_shift[SLICE_BITS-1:0];
    work_merged = (work_q & ~(SLICE_MASK << slice_lsb)) | (NUM_BITS'(slice_sum) << slice_lsb);
  end

  adder_nbit #(
    .N(SLICE_BITS)
  ) u_slice_adder (
    .a        (slice_a),
    .b        (slice_b),
    .carry_in (carry_q),
    .sum      (slice_sum),
    .overflow (slice_carry)
  );

  // Next-state logic: accept operands in IDLE/DONE, walk the slices in ADD, publish on the last slice.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    work_d     = work_q;
    idx_d      = idx_q;
    sum_d      = sum_q;
    overflow_d = overflow_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = carry_in;
          work_d  = '0;
          idx_d   = '0;
          state_d = ADD;
        end else begin
          state_d = IDLE;
        end
      end
      ADD: begin
        work_d  = work_merged;
        carry_d = slice_carry;
        if (idx_q == LAST_IDX) begin
          sum_d      = work_merged;
          overflow_d = slice_carry;
          idx_d      = '0;
          state_d    = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, working and result registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      carry_q    <= 1'b0;
      work_q     <= '0;
      idx_q      <= '0;
      sum_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      carry_q    <= carry_d;
      work_q     <= work_d;
      idx_q      <= idx_d;
      sum_q      <= sum_d;
      overflow_q <= overflow_d;
    end
  end

  assign busy     = (state_q == ADD);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_flex_serial_adder.sv
// Randomised and directed checks of flex_serial_adder against a plain-arithmetic reference.
module tb_flex_serial_adder;

  localparam int NB = 16;
  localparam int SB = 4;
  localparam int NS = NB / SB;

  logic          clk = 1'b0;
  logic          n_rst;
  logic          start;
  logic [NB-1:0] a, b;
  logic          carry_in;
  logic          busy, done;
  logic [NB-1:0] sum;
  logic          overflow;

  logic          start8;
  logic [7:0]    a8, b8;
  logic          cin8;
  logic          busy8, done8;
  logic [7:0]    sum8;
  logic          ov8;

  int checks = 0;
  int passes = 0;

  logic [NB-1:0] hold_sum;
  logic          hold_ov;

  always #5 clk = ~clk;

  flex_serial_adder #(.NUM_BITS(NB), .SLICE_BITS(SB)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .a(a), .b(b), .carry_in(carry_in),
    .busy(busy), .done(done), .sum(sum), .overflow(overflow)
  );

  flex_serial_adder #(.NUM_BITS(8), .SLICE_BITS(8)) dut8 (
    .clk(clk), .n_rst(n_rst), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .overflow(ov8)
  );

  // Operands must be known whenever a start can be accepted.
  always @(posedge clk) begin
    if (n_rst === 1'b1 && start === 1'b1 && busy === 1'b0 && $isunknown({a, b, carry_in}))
      $error("[TB] unknown operands at accepted start (16-bit)");
    if (n_rst === 1'b1 && start8 === 1'b1 && busy8 === 1'b0 && $isunknown({a8, b8, cin8}))
      $error("[TB] unknown operands at accepted start (8-bit)");
  end

  function automatic logic [NB:0] ref_add(input logic [NB-1:0] x, input logic [NB-1:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + (NB+1)'(c);
  endfunction

  function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + 9'(c);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a        = 16'($urandom);
    b        = 16'($urandom);
    carry_in = 1'($urandom);
  endtask

  task automatic test_reset();
    n_rst = 1'b0; start = 1'b0; a = '0; b = '0; carry_in = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    #3;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passes++;
    checks++; if (sum !== 16'h0) $display("[TB] FAIL reset_sum: got %h expected 0000", sum); else passes++;
    checks++; if (overflow !== 1'b0) $display("[TB] FAIL reset_ovf: got %b expected 0", overflow); else passes++;
    checks++; if (sum8 !== 8'h0) $display("[TB] FAIL reset_sum8: got %h expected 00", sum8); else passes++;
    tick(); tick();
    n_rst = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) $display("[TB] FAIL idle_after_reset: got busy=%b done=%b expected 0/0", busy, done); else passes++;
    hold_sum = '0;
    hold_ov  = 1'b0;
  endtask

  task automatic test_directed();
    logic [NB-1:0] va [3] = '{16'h1234, 16'hFFFF, 16'hFFFF};
    logic [NB-1:0] vb [3] = '{16'h4321, 16'h0000, 16'hFFFF};
    logic          vc [3] = '{1'b0, 1'b1, 1'b1};
    logic [NB:0]   r;
    for (int i = 0; i < 3; i++) begin
      start = 1'b1; a = va[i]; b = vb[i]; carry_in = vc[i];
      r = ref_add(va[i], vb[i], vc[i]);
      tick();
      start = 1'b0;
      scramble();
      for (int c = 0; c <= NS; c++) begin
        checks++; if (busy !== (c < NS)) $display("[TB] FAIL dir_busy[%0d,c%0d]: got %b expected %b", i, c, busy, (c < NS)); else passes++;
        checks++; if (done !== (c == NS)) $display("[TB] FAIL dir_done[%0d,c%0d]: got %b expected %b", i, c, done, (c == NS)); else passes++;
        if (c < NS) begin
          checks++; if (sum !== hold_sum) $display("[TB] FAIL dir_hold[%0d,c%0d]: got %h expected %h", i, c, sum, hold_sum); else passes++;
          tick();
          scramble();
        end else begin
          checks++; if (sum !== r[NB-1:0]) $display("[TB] FAIL dir_sum[%0d]: got %h expected %h", i, sum, r[NB-1:0]); else passes++;
          checks++; if (overflow !== r[NB]) $display("[TB] FAIL dir_ovf[%0d]: got %b expected %b", i, overflow, r[NB]); else passes++;
          hold_sum = r[NB-1:0];
          hold_ov  = r[NB];
        end
      end
      tick();
      checks++; if (done !== 1'b0 || sum !== hold_sum) $display("[TB] FAIL dir_after[%0d]: got done=%b sum=%h expected 0/%h", i, done, sum, hold_sum); else passes++;
    end
  endtask

  task automatic test_random();
    logic [NB-1:0] x, y;
    logic          c;
    logic [NB:0]   r;
    int            n;
    for (int i = 0; i < 20; i++) begin
      x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
      r = ref_add(x, y, c);
      start = 1'b1; a = x; b = y; carry_in = c;
      tick();
      start = 1'b0;
      scramble();
      n = 0;
      while (done !== 1'b1 && n < 10) begin
        tick();
        n++;
      end
      checks++; if (n != NS) $display("[TB] FAIL rnd_latency[%0d]: got %0d expected %0d", i, n, NS); else passes++;
      checks++; if (sum !== r[NB-1:0] || overflow !== r[NB]) $display("[TB] FAIL rnd_result[%0d]: got %b_%h expected %b_%h", i, overflow, sum, r[NB], r[NB-1:0]); else passes++;
      hold_sum = r[NB-1:0];
      hold_ov  = r[NB];
      repeat (1 + ($urandom % 3)) tick();
    end
  endtask

  task automatic test_start_ignored();
    int            pulses;
    logic [NB-1:0] got_sum;
    logic          got_ov;
    pulses = 0; got_sum = 'x; got_ov = 1'bx;
    start = 1'b1; a = 16'h00FF; b = 16'h0001; carry_in = 1'b0;
    tick();
    start = 1'b0;
    tick();
    start = 1'b1; a = 16'hFFFF; b = 16'hFFFF; carry_in = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (done === 1'b1) begin
        pulses++;
        got_sum = sum;
        got_ov  = overflow;
      end
      tick();
    end
    checks++; if (pulses != 1) $display("[TB] FAIL ign_pulses: got %0d expected 1", pulses); else passes++;
    checks++; if (got_sum !== 16'h0100) $display("[TB] FAIL ign_sum: got %h expected 0100", got_sum); else passes++;
    checks++; if (got_ov !== 1'b0) $display("[TB] FAIL ign_ovf: got %b expected 0", got_ov); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL ign_idle: got busy=%b expected 0", busy); else passes++;
    hold_sum = 16'h0100;
    hold_ov  = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [NB-1:0] oa [3];
    logic [NB-1:0] ob [3];
    logic          oc [3];
    logic [NB:0]   r;
    logic          exp_busy, exp_done;
    int            k;
    for (int i = 0; i < 3; i++) begin
      oa[i] = 16'($urandom); ob[i] = 16'($urandom); oc[i] = 1'($urandom);
    end
    start = 1'b1; a = oa[0]; b = ob[0]; carry_in = oc[0];
    tick();
    for (int c = 0; c < 20; c++) begin
      exp_done = (c <= 14) && (c % 5 == 4);
      exp_busy = (c < 14) && (c % 5 != 4);
      checks++; if (busy !== exp_busy) $display("[TB] FAIL b2b_busy[c%0d]: got %b expected %b", c, busy, exp_busy); else passes++;
      checks++; if (done !== exp_done) $display("[TB] FAIL b2b_done[c%0d]: got %b expected %b", c, done, exp_done); else passes++;
      if (c == 11) start = 1'b0;
      if (exp_done) begin
        k = c / 5;
        r = ref_add(oa[k], ob[k], oc[k]);
        checks++; if (sum !== r[NB-1:0] || overflow !== r[NB]) $display("[TB] FAIL b2b_result[%0d]: got %b_%h expected %b_%h", k, overflow, sum, r[NB], r[NB-1:0]); else passes++;
        hold_sum = r[NB-1:0];
        hold_ov  = r[NB];
        if (k < 2) begin
          a = oa[k+1]; b = ob[k+1]; carry_in = oc[k+1];
        end else begin
          scramble();
        end
      end else begin
        checks++; if (sum !== hold_sum || overflow !== hold_ov) $display("[TB] FAIL b2b_hold[c%0d]: got %b_%h expected %b_%h", c, overflow, sum, hold_ov, hold_sum); else passes++;
        scramble();
      end
      tick();
    end
  endtask

  task automatic test_reset_during_add();
    start = 1'b1; a = 16'h0F0F; b = 16'h1010; carry_in = 1'b0;
    tick();
    start = 1'b0;
    repeat (NS) tick();
    checks++; if (sum !== 16'h1F1F) $display("[TB] FAIL rst_pre_sum: got %h expected 1F1F", sum); else passes++;
    tick();
    start = 1'b1; a = 16'hAAAA; b = 16'h5555; carry_in = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 n_rst = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL rst_mid_done: got %b expected 0", done); else passes++;
    checks++; if (sum !== 16'h0 || overflow !== 1'b0) $display("[TB] FAIL rst_mid_result: got %b_%h expected 0_0000", overflow, sum); else passes++;
    tick();
    n_rst = 1'b1;
    hold_sum = '0;
    hold_ov  = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++; if (done !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL rst_after[c%0d]: got busy=%b done=%b expected 0/0", c, busy, done); else passes++;
    end
  endtask

  task automatic test_single_slice();
    logic [7:0] x, y;
    logic       c;
    logic [8:0] r;
    start8 = 1'b1; a8 = 8'h80; b8 = 8'h80; cin8 = 1'b1;
    tick();
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    checks++; if (busy8 !== 1'b1 || done8 !== 1'b0) $display("[TB] FAIL ss_busy: got busy=%b done=%b expected 1/0", busy8, done8); else passes++;
    tick();
    checks++; if (done8 !== 1'b1 || busy8 !== 1'b0) $display("[TB] FAIL ss_done: got busy=%b done=%b expected 0/1", busy8, done8); else passes++;
    checks++; if (sum8 !== 8'h01 || ov8 !== 1'b1) $display("[TB] FAIL ss_result: got %b_%h expected 1_01", ov8, sum8); else passes++;
    tick();
    checks++; if (done8 !== 1'b0 || sum8 !== 8'h01) $display("[TB] FAIL ss_hold: got done=%b sum=%h expected 0/01", done8, sum8); else passes++;
    for (int i = 0; i < 5; i++) begin
      x = 8'($urandom); y = 8'($urandom); c = 1'($urandom);
      r = ref_add8(x, y, c);
      start8 = 1'b1; a8 = x; b8 = y; cin8 = c;
      tick();
      start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
      tick();
      checks++; if (done8 !== 1'b1 || sum8 !== r[7:0] || ov8 !== r[8]) $display("[TB] FAIL ss_rnd[%0d]: got done=%b %b_%h expected 1 %b_%h", i, done8, ov8, sum8, r[8], r[7:0]); else passes++;
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_ignored();
    test_back_to_back();
    test_single_slice();
    test_reset_during_add();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
